// File: rtl/pb_mode_select_if.sv
// pb_mode_select_if
// Groups the pushbutton inputs and the select/pulse outputs of pb_mode_select.
//   pb_n      raw active-low buttons (asynchronous), driven by the board side
//   pb_level  debounced level per button, 1 = pressed
//   pb_press  one-cycle pulse per accepted press (or auto-repeat)
//   sel       registered 2-bit operation select for the result mux
//   sel_chg   one-cycle pulse coincident with every sel update
//   dbg_state per-button FSM state, {button1, button0}, 2 bits each
// Handshake: there is no valid/ready pair on this bus. pb_press and sel_chg
// are self-qualifying single-cycle strobes; the consumer must sample them
// every cycle and cannot apply backpressure. Levels are valid every cycle.
// Modports: master = board/bench side, slave = pb_mode_select.
interface pb_mode_select_if;
  logic [1:0] pb_n;
  logic [1:0] pb_level;
  logic [1:0] pb_press;
  logic [1:0] sel;
  logic       sel_chg;
  logic [3:0] dbg_state;

  modport master (
    output pb_n,
    input  pb_level, pb_press, sel, sel_chg, dbg_state
  );

  modport slave (
    input  pb_n,
    output pb_level, pb_press, sel, sel_chg, dbg_state
  );
endinterface

// File: rtl/pb_mode_select.sv
// pb_mode_select
// Synchronises and debounces the two board pushbuttons, turns every accepted
// press into a single one-cycle pulse and toggles the matching bit of the
// registered operation select (00 arith, 01 compare, 1x logical).
// Ports:
//   clk   board clock
//   rst   synchronous active-high reset, highest priority
//   bus   pb_mode_select_if.slave (pb_n in; pb_level, pb_press, sel,
//         sel_chg, dbg_state out)
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>= 2)
//   REPEAT_CYCLES    auto-repeat period while held (>= 2)
// Optional feature macro: PB_AUTOREPEAT_EN adds a per-button repeat counter
// that re-fires pb_press every REPEAT_CYCLES while the button stays pressed.
module pb_mode_select #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input logic              clk,
  input logic              rst,
  pb_mode_select_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef PB_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);
`endif

  // Both counters compare against PARAM-1, which needs PARAM >= 2.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("pb_mode_select: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  // Two-flop synchroniser on the raw active-low inputs; resets to released.
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= bus.pb_n;
      sync2_q <= sync1_q;
    end
  end

  logic [1:0] press_d_vec;
  logic [1:0] press_q_vec;
  logic [1:0] level_vec;
  logic [3:0] state_vec;

  for (genvar g = 0; g < 2; g++) begin : g_btn
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             press_d;
    logic             pressed;
`ifdef PB_AUTOREPEAT_EN
    logic [RPT_W-1:0] rpt_q;
`endif

    assign pressed = ~sync2_q[g];

    // The press pulse is decided from the current state so that pb_press,
    // sel and sel_chg can all register on the same edge.
    always_comb begin
      press_d = 1'b0;
      if (state_q == ST_PRESS_WAIT && pressed && cnt_q == CNT_MAX) begin
        press_d = 1'b1;
      end
`ifdef PB_AUTOREPEAT_EN
      if (state_q == ST_PRESSED && pressed && rpt_q == RPT_MAX) begin
        press_d = 1'b1;
      end
`endif
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_RELEASED;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
`ifdef PB_AUTOREPEAT_EN
        rpt_q   <= '0;
`endif
      end else begin
        press_q <= press_d;
        case (state_q)
          ST_RELEASED: begin
            if (pressed) begin
              state_q <= ST_PRESS_WAIT;
              cnt_q   <= '0;
            end
          end
          ST_PRESS_WAIT: begin
            if (!pressed) begin
              state_q <= ST_RELEASED;
            end else if (cnt_q == CNT_MAX) begin
              state_q <= ST_PRESSED;
              level_q <= 1'b1;
`ifdef PB_AUTOREPEAT_EN
              rpt_q   <= '0;
`endif
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          ST_PRESSED: begin
            if (!pressed) begin
              state_q <= ST_RELEASE_WAIT;
              cnt_q   <= '0;
            end
`ifdef PB_AUTOREPEAT_EN
            else if (rpt_q == RPT_MAX) begin
              rpt_q <= '0;
            end else begin
              rpt_q <= rpt_q + RPT_ONE;
            end
`endif
          end
          ST_RELEASE_WAIT: begin
            // A release bounce returns to PRESSED without a pulse; the
            // repeat counter was held here so the repeat cadence resumes.
            if (pressed) begin
              state_q <= ST_PRESSED;
            end else if (cnt_q == CNT_MAX) begin
              state_q <= ST_RELEASED;
              level_q <= 1'b0;
`ifdef PB_AUTOREPEAT_EN
              rpt_q   <= '0;
`endif
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: state_q <= ST_RELEASED;
        endcase
      end
    end

    assign press_d_vec[g]       = press_d;
    assign press_q_vec[g]       = press_q;
    assign level_vec[g]         = level_q;
    assign state_vec[2*g +: 2]  = state_q;
  end

  // Simultaneous presses toggle both bits on one edge with one sel_chg.
  logic [1:0] sel_q;
  logic       sel_chg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= 2'b00;
      sel_chg_q <= 1'b0;
    end else begin
      sel_q     <= sel_q ^ press_d_vec;
      sel_chg_q <= |press_d_vec;
    end
  end

  assign bus.pb_level  = level_vec;
  assign bus.pb_press  = press_q_vec;
  assign bus.sel       = sel_q;
  assign bus.sel_chg   = sel_chg_q;
  assign bus.dbg_state = state_vec;

endmodule

// File: tb/tb_pb_mode_select.sv
// tb_pb_mode_select
// Drives pb_n with debounce-relevant patterns and checks pb_press/sel/sel_chg
// events against an expected-event queue filled at stimulus time.
// Queue entry: {observe_cycle[19:0], press_mask[1:0], sel_after[1:0]}.
module tb_pb_mode_select;
  localparam int D = 4;
  localparam int R = 10;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pulses0 = 0;
  logic [1:0] exp_sel = 2'b00;
  logic [W-1:0] exp_q[$];

  pb_mode_select_if bus();

  pb_mode_select #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (bus.pb_press != 2'b00 || bus.sel_chg) begin
      if (bus.pb_press[0]) pulses0++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", {29'd0, bus.pb_press, bus.sel_chg}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_cycle", cyc, {12'd0, e[23:4]});
        chk("sb_press", {30'd0, bus.pb_press}, {30'd0, e[3:2]});
        chk("sb_sel",   {30'd0, bus.sel},      {30'd0, e[1:0]});
        chk("sb_chg",   {31'd0, bus.sel_chg},  32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // First pulse observed at p; repeats every R cycles while the FSM still
  // sees the button pressed (up to two edges after the release is driven).
  task automatic expect_press(input logic [1:0] mask, input int p, input int rel);
    exp_sel = exp_sel ^ mask;
    exp_q.push_back({20'(p), mask, exp_sel});
`ifdef PB_AUTOREPEAT_EN
    for (int t = p + R; t <= rel + 2; t += R) begin
      exp_sel = exp_sel ^ mask;
      exp_q.push_back({20'(t), mask, exp_sel});
    end
`endif
  endtask

  task automatic release_btn(input logic [1:0] mask);
    bus.pb_n = bus.pb_n | mask;
    tick(D + 2);
    chk("rel_lvl_hold", {30'd0, bus.pb_level & mask}, {30'd0, mask});
    tick(1);
    chk("rel_lvl_clr", {30'd0, bus.pb_level & mask}, 32'd0);
    tick(4);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk(tag, exp_q.size(), 32'd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
    exp_sel = 2'b00;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int p;
    int rel;
    bus.pb_n = 2'b11;

    // Reset: 3 cycles, then outputs stay quiet for 20 cycles.
    tick(3);
    chk("rst_state", {28'd0, bus.dbg_state}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("rst_idle", {25'd0, bus.pb_level, bus.pb_press, bus.sel, bus.sel_chg}, 32'd0);
    end

    // Clean press of button 0 held 30 cycles.
    c = cyc;
    bus.pb_n[0] = 1'b0;
    expect_press(2'b01, c + D + 3, c + 30);
    tick(D + 2);
    chk("clean_lvl_pre", {31'd0, bus.pb_level[0]}, 32'd0);
    chk("clean_sel_pre", {30'd0, bus.sel}, 32'd0);
    tick(1);
    chk("clean_lvl", {31'd0, bus.pb_level[0]}, 32'd1);
    chk("clean_sel", {30'd0, bus.sel}, 32'd1);
    tick(30 - (D + 3));
    release_btn(2'b01);
    wait_drain("clean_drain");

    // Bounce on button 1: 2 low / 2 high, never long enough to accept.
    for (int i = 0; i < 5; i++) begin
      bus.pb_n[1] = 1'b0;
      tick(2);
      chk("bounce_lvl_lo", {31'd0, bus.pb_level[1]}, 32'd0);
      bus.pb_n[1] = 1'b1;
      tick(2);
      chk("bounce_lvl_hi", {31'd0, bus.pb_level[1]}, 32'd0);
    end
    tick(10);
    chk("bounce_sel", {30'd0, bus.sel}, {30'd0, exp_sel});
    chk("bounce_state", {28'd0, bus.dbg_state}, 32'd0);

    // Reset mid-debounce: partial count discarded, held button re-accepted.
    bus.pb_n[0] = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    exp_sel = 2'b00;
    c = cyc;
    expect_press(2'b01, c + D + 3, c + 20);
    tick(D + 2);
    chk("rmid_sel_pre", {30'd0, bus.sel}, 32'd0);
    tick(20 - (D + 2));
    release_btn(2'b01);
    wait_drain("rmid_drain");

    // Simultaneous press of both buttons from sel = 00.
    do_reset(2);
    c = cyc;
    bus.pb_n = 2'b00;
    expect_press(2'b11, c + D + 3, c + 12);
    tick(D + 2);
    chk("sim_sel_pre", {30'd0, bus.sel}, 32'd0);
    tick(1);
    chk("sim_sel", {30'd0, bus.sel}, 32'd3);
    tick(12 - (D + 3));
    release_btn(2'b11);
    wait_drain("sim_drain");

    // Hold button 0 for 40 cycles after acceptance.
    do_reset(2);
    pulses0 = 0;
    c = cyc;
    p = c + D + 3;
    rel = p + 40;
    bus.pb_n[0] = 1'b0;
    expect_press(2'b01, p, rel);
    tick(rel - c);
    release_btn(2'b01);
    wait_drain("hold_drain");
    chk("hold_sel0", {31'd0, bus.sel[0]}, 32'd1);
`ifdef PB_AUTOREPEAT_EN
    chk("hold_pulses", pulses0, 32'd5);
`else
    chk("hold_pulses", pulses0, 32'd1);
`endif

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
